load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage directly downstream of the ALU. It takes ALU_result as the effective address
//  and rs2 data as store data. It drives a single-master req/ack data bus, with byte-lane selects
//  and load alignment/extension. It stalls the core while a bus transaction is outstanding, then
//  returns a registered, sign/zero-extended load value to writeback.
// PARAMETERS
//  TIMEOUT   255  max cycles bus_req may stay high without bus_ack before abort (1..65535)
// PORTS
//  clk         in   1   system clock, rising edge
//  nRst        in   1   asynchronous active-low reset
//  mem_read    in   1   load request from control (level, held while lsu_busy)
//  mem_write   in   1   store request from control (level, held while lsu_busy)
//  funct3      in   3   instruction[14:12]: access size/sign
//  ALU_result  in   32  effective address
//  store_data  in   32  rs2 value
//  lsu_busy    out  1   stall core (combinational)
//  load_data   out  32  aligned, extended load result (registered)
//  load_valid  out  1   1-cycle pulse: load_data valid
//  bus_err     out  1   1-cycle pulse: access aborted on TIMEOUT
//  bus_addr    out  32  word address {addr[31:2],2'b00}
//  bus_wdata   out  32  lane-replicated store data
//  bus_sel     out  4   byte enables
//  bus_we      out  1   1 = write
//  bus_req     out  1   request, held until bus_ack
//  bus_ack     in   1   slave completion, 1 cycle; bus_rdata valid with it
//  bus_rdata   in   32  read data
//  misaligned  out  1   1-cycle fault pulse (only with LSU_MISALIGN_TRAP_EN)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; timeout counter 0. nRst low mid-access drops bus_req at once.
//    The access is abandoned; no load_valid or bus_err is produced.
//  - FSM IDLE/REQ/DONE:
//    - IDLE or DONE with mem_read|mem_write: latch addr/funct3/data/we, go REQ.
//    - REQ: bus_req=1; bus_ack -> latch result, go DONE; counter==TIMEOUT-1 -> go DONE with error flag.
//    - DONE: load_valid pulses for a completed load, or bus_err pulses on timeout.
//      A new request is accepted in the same cycle; otherwise go IDLE.
//  - mem_read and mem_write both high: load wins; the store is dropped.
//  - lsu_busy = (IDLE|DONE)&(mem_read|mem_write) | REQ. It is low in the DONE cycle so the core advances.
//  - Latency: request at cycle N; bus_req from N+1. bus_ack at cycle M gives load_valid at M+1.
//    Minimum 2 cycles when ack comes in the first REQ cycle.
//  - Bus outputs are registered and stable for the whole REQ phase. bus_ack outside REQ is ignored.
//  - Timeout counter clears on REQ entry. No ack after TIMEOUT REQ cycles -> abort:
//    load_data=0, bus_err pulse, no load_valid.
//  - funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 treated as W.
//  - bus_sel: B = 4'b0001<<a[1:0]; H = 4'b0011<<{a[1],1'b0}; W = 4'b1111. bus_sel is driven for loads too.
//  - bus_wdata: B = {4{d[7:0]}}; H = {2{d[15:0]}}; W = d.
//  - Load: r = bus_rdata >> (8*a[1:0]) for B, >> (16*a[1]) for H.
//    B/H sign-extend r[7]/r[15]; BU/HU zero-extend.
//  - load_data holds its last value until the next load completes or a timeout occurs.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN:
//   - Defined: H with a[0]=1, or W with a[1:0]!=0, is not issued to the bus.
//     IDLE goes straight to DONE and misaligned pulses in DONE.
//     There is no load_valid, load_data is unchanged, and lsu_busy is high for 1 cycle.
//   - Undefined: misaligned low address bits are ignored and the access proceeds aligned-down.
//     The misaligned port is absent.
// TESTING
//  1 SW: addr 0x1004, data 0xDEADBEEF, ack after 3 cycles.
//    -> bus_addr 0x1004, sel 1111, we 1, wdata DEADBEEF; busy for 4 cycles; no load_valid.
//  2 LB: addr 0x2003, rdata 0x80FF_0000 -> sel 1000, load_data 0xFFFFFF80.
//    LBU at the same address -> 0x00000080.
//  3 LH: addr 0x2002, rdata 0x8001_1234 -> sel 1100, load_data 0xFFFF8001.
//    LHU -> 0x00008001. SH data 0x0000ABCD at 0x2002 -> wdata ABCDABCD, sel 1100.
//  4 Back-to-back: LW ack in the 1st REQ cycle, then a new SB presented in the DONE cycle.
//    -> accepted without an IDLE cycle; load_valid and the new bus_req are 1 cycle apart.
//  5 TIMEOUT=4, never ack -> bus_req high exactly 4 cycles, then bus_err pulse, load_data 0, return IDLE.
//    nRst pulse mid-REQ -> bus_req 0 immediately, no pulses.
//  6 With LSU_MISALIGN_TRAP_EN: LW at 0x3001 -> no bus_req, misaligned pulse 1 cycle after request.
//    Without the macro: sel 1111, addr 0x3000.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage driving a req/ack data bus with lane selects and load extension.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of aligning them down.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALU_result,
  input  logic [31:0] store_data,
  output logic        lsu_busy,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_we,
  output logic        bus_req,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic        accept, is_b, is_h, q_b, q_h, mis_n;
  logic [3:0]  sel_n;
  logic [31:0] wdata_n, rb, rh, ext;
  // Request decode: lane selects, replicated store data and alignment check for the incoming access
  always_comb begin
    accept   = (state != REQ) & (mem_read | mem_write);
    lsu_busy = accept | (state == REQ);
    is_b     = funct3[1:0] == 2'b00;
    is_h     = funct3[1:0] == 2'b01;
    sel_n    = is_b ? 4'b0001 << ALU_result[1:0] : is_h ? 4'b0011 << {ALU_result[1], 1'b0} : 4'b1111;
    wdata_n  = is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
    mis_n    = (is_h & ALU_result[0]) | (~is_b & ~is_h & |ALU_result[1:0]);
  end
  // Load alignment and sign/zero extension from the latched size and byte lane
  always_comb begin
    q_b = f3_q[1:0] == 2'b00;
    q_h = f3_q[1:0] == 2'b01;
    rb  = bus_rdata >> {lane_q, 3'b000};
    rh  = bus_rdata >> {lane_q[1], 4'b0000};
    ext = q_b ? {{24{~f3_q[2] & rb[7]}}, rb[7:0]} :
          q_h ? {{16{~f3_q[2] & rh[15]}}, rh[15:0]} : bus_rdata;
  end
  // IDLE/REQ/DONE sequencer with registered bus outputs and single-cycle result pulses
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      cnt        <= '0;
      lane_q     <= '0;
      f3_q       <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_sel    <= '0;
      bus_we     <= 1'b0;
      bus_req    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
      if (accept) begin
        lane_q    <= ALU_result[1:0];
        f3_q      <= funct3;
        bus_addr  <= {ALU_result[31:2], 2'b00};
        bus_sel   <= sel_n;
        bus_wdata <= wdata_n;
        bus_we    <= ~mem_read;
        cnt       <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis_n) begin
          state      <= DONE;
          misaligned <= 1'b1;
        end else begin
          state   <= REQ;
          bus_req <= 1'b1;
        end
`else
        state   <= REQ;
        bus_req <= 1'b1;
`endif
      end else if (state == REQ) begin
        if (bus_ack) begin
          state   <= DONE;
          bus_req <= 1'b0;
          if (!bus_we) begin
            load_data  <= ext;
            load_valid <= 1'b1;
          end
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          state     <= DONE;
          bus_req   <= 1'b0;
          bus_err   <= 1'b1;
          load_data <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
`ifndef LSU_MISALIGN_TRAP_EN
  logic unused;
  assign unused = mis_n;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors plus hand-written corner sequences for load_store_unit (TIMEOUT=4).
module tb_load_store_unit;
  logic        clk = 0, nRst = 0, mem_read = 0, mem_write = 0, bus_ack = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] ALU_result = 0, store_data = 0, bus_rdata = 0;
  logic        lsu_busy, load_valid, bus_err, bus_we, bus_req;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_ld = 0;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, sd, rdata, baddr, wdata, ld;
    logic [3:0]  sel;
    int          dly;
  } vec_t;
  vec_t v[$];

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .nRst(nRst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .ALU_result(ALU_result), .store_data(store_data), .lsu_busy(lsu_busy), .load_data(load_data),
    .load_valid(load_valid), .bus_err(bus_err), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_req(bus_req), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sd, input logic [31:0] rdata, input logic [3:0] sel,
                              input logic [31:0] baddr, input logic [31:0] wdata, input logic [31:0] ld,
                              input int dly);
    vec_t t;
    t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = addr; t.sd = sd; t.rdata = rdata;
    t.sel = sel; t.baddr = baddr; t.wdata = wdata; t.ld = ld; t.dly = dly;
    return t;
  endfunction

  task automatic run(input vec_t t);
    int busy = 0;
    @(negedge clk);
    mem_read = t.rd; mem_write = t.wr; funct3 = t.f3; ALU_result = t.addr; store_data = t.sd;
    #1 if (lsu_busy) busy++;
    for (int i = 1; i <= t.dly; i++) begin
      @(negedge clk);
      #1 chk1("bus_req_held", bus_req, 1'b1);
      if (lsu_busy) busy++;
      if (i == 1) begin
        chk("bus_addr", bus_addr, t.baddr);
        chk("bus_sel", {28'd0, bus_sel}, {28'd0, t.sel});
        chk1("bus_we", bus_we, t.wr & ~t.rd);
        if (t.wr & ~t.rd) chk("bus_wdata", bus_wdata, t.wdata);
      end
      if (i == t.dly) begin
        bus_ack = 1; bus_rdata = t.rdata;
      end
    end
    @(negedge clk);
    bus_ack = 0; mem_read = 0; mem_write = 0;
    #1 if (lsu_busy) busy++;
    chk1("bus_req_done", bus_req, 1'b0);
    chk1("load_valid", load_valid, t.rd);
    if (t.rd) last_ld = t.ld;
    chk("load_data", load_data, last_ld);
    chk("busy_cycles", busy, t.dly + 1);
    @(negedge clk);
    #1 chk1("load_valid_end", load_valid, 1'b0);
  endtask

  initial begin
    logic seen;
    int   n;
    // SW, ack in 3rd REQ cycle
    v.push_back(mk(0, 1, 3'b010, 32'h1004, 32'hDEADBEEF, 32'h0, 4'b1111, 32'h1004, 32'hDEADBEEF, 32'h0, 3));
    v.push_back(mk(1, 0, 3'b000, 32'h2003, 32'h0, 32'h80FF0000, 4'b1000, 32'h2000, 32'h0, 32'hFFFFFF80, 1));
    v.push_back(mk(1, 0, 3'b100, 32'h2003, 32'h0, 32'h80FF0000, 4'b1000, 32'h2000, 32'h0, 32'h00000080, 1));
    v.push_back(mk(1, 0, 3'b001, 32'h2002, 32'h0, 32'h80011234, 4'b1100, 32'h2000, 32'h0, 32'hFFFF8001, 1));
    v.push_back(mk(1, 0, 3'b101, 32'h2002, 32'h0, 32'h80011234, 4'b1100, 32'h2000, 32'h0, 32'h00008001, 2));
    v.push_back(mk(0, 1, 3'b001, 32'h2002, 32'h0000ABCD, 32'h0, 4'b1100, 32'h2000, 32'hABCDABCD, 32'h0, 1));
    v.push_back(mk(0, 1, 3'b000, 32'h1001, 32'h000000A5, 32'h0, 4'b0010, 32'h1000, 32'hA5A5A5A5, 32'h0, 1));
    v.push_back(mk(1, 0, 3'b000, 32'h1001, 32'h0, 32'h00007F00, 4'b0010, 32'h1000, 32'h0, 32'h0000007F, 1));
    v.push_back(mk(1, 0, 3'b110, 32'h4000, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h4000, 32'h0, 32'hCAFEF00D, 1));
    v.push_back(mk(1, 1, 3'b010, 32'h5000, 32'h11111111, 32'h22222222, 4'b1111, 32'h5000, 32'h0, 32'h22222222, 1));
    v.push_back(mk(1, 0, 3'b001, 32'h2000, 32'h0, 32'h80011234, 4'b0011, 32'h2000, 32'h0, 32'h00001234, 1));
`ifndef LSU_MISALIGN_TRAP_EN
    v.push_back(mk(1, 0, 3'b010, 32'h3001, 32'h0, 32'h12345678, 4'b1111, 32'h3000, 32'h0, 32'h12345678, 1));
`endif
    // reset state
    @(negedge clk);
    #1 chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_busy", lsu_busy, 1'b0);
    chk1("rst_load_valid", load_valid, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    @(negedge clk);
    nRst = 1;
    foreach (v[i]) run(v[i]);
    // bus_ack outside REQ is ignored
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 0;
    #1 chk1("stray_ack_valid", load_valid, 1'b0);
    chk("stray_ack_data", load_data, last_ld);
    // back-to-back: LW acked in first REQ cycle, SB presented in DONE
    @(negedge clk);
    mem_read = 1; funct3 = 3'b010; ALU_result = 32'h6000;
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h01020304;
    @(negedge clk);
    bus_ack = 0; mem_read = 0; mem_write = 1; funct3 = 3'b000; ALU_result = 32'h6002; store_data = 32'h5A;
    #1 chk1("b2b_valid", load_valid, 1'b1);
    chk("b2b_data", load_data, 32'h01020304);
    last_ld = 32'h01020304;
    chk1("b2b_busy_done", lsu_busy, 1'b1);
    chk1("b2b_req_done", bus_req, 1'b0);
    @(negedge clk);
    #1 chk1("b2b_req_next", bus_req, 1'b1);
    chk1("b2b_valid_next", load_valid, 1'b0);
    chk("b2b_sel", {28'd0, bus_sel}, 32'h4);
    chk("b2b_wdata", bus_wdata, 32'h5A5A5A5A);
    chk1("b2b_we", bus_we, 1'b1);
    bus_ack = 1;
    @(negedge clk);
    bus_ack = 0; mem_write = 0;
    #1 chk1("b2b_store_no_valid", load_valid, 1'b0);
    chk("b2b_store_keeps", load_data, last_ld);
    // timeout: never ack
    @(negedge clk);
    mem_read = 1; funct3 = 3'b010; ALU_result = 32'h7000;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 if (!bus_req) break;
      n++;
    end
    mem_read = 0;
    chk("timeout_req_cycles", n, 4);
    chk1("timeout_err", bus_err, 1'b1);
    chk1("timeout_no_valid", load_valid, 1'b0);
    chk("timeout_data", load_data, 32'h0);
    last_ld = 0;
    @(negedge clk);
    #1 chk1("timeout_err_clear", bus_err, 1'b0);
    chk1("timeout_idle", lsu_busy, 1'b0);
    // reset mid-REQ: bus_req drops at once, nothing reported afterwards
    run(mk(1, 0, 3'b010, 32'h7004, 32'h0, 32'h0BADF00D, 4'b1111, 32'h7004, 32'h0, 32'h0BADF00D, 1));
    @(negedge clk);
    mem_read = 1; funct3 = 3'b010; ALU_result = 32'h8000;
    @(negedge clk);
    #1 chk1("rreq_req", bus_req, 1'b1);
    @(negedge clk);
    #1 nRst = 0; mem_read = 0;
    #1 chk1("rreq_drop", bus_req, 1'b0);
    chk("rreq_data", load_data, 32'h0);
    last_ld = 0;
    @(negedge clk);
    nRst = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 seen = seen | load_valid | bus_err | bus_req;
    end
    chk1("rreq_no_pulses", seen, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    mem_read = 1; funct3 = 3'b010; ALU_result = 32'h3001;
    #1 chk1("mis_busy", lsu_busy, 1'b1);
    @(negedge clk);
    mem_read = 0;
    #1 chk1("mis_pulse", misaligned, 1'b1);
    chk1("mis_no_req", bus_req, 1'b0);
    chk1("mis_no_valid", load_valid, 1'b0);
    chk1("mis_busy_done", lsu_busy, 1'b0);
    chk("mis_data", load_data, last_ld);
    @(negedge clk);
    #1 chk1("mis_clear", misaligned, 1'b0);
    chk1("mis_still_no_req", bus_req, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
